vpu_stall_ctrl: RTL and testbench

Parametrised issue-stage stall controller for the vector processing unit. Holds a per-register busy scoreboard and per-unit outstanding-operation counters. From these it asserts `stall` for RAW/WAW hazards, unit back-pressure and the barrier opcode. It sits between decode and the execution units (unit 0 = VLS, unit 1 = VRB by default) and supersedes the single-opcode combinational stall check.

---
 rtl/vpu_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_vpu_stall_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vpu_stall_ctrl.sv
// Issue-stage stall controller for the vector unit: register busy scoreboard,
// per-unit outstanding-op counters and stall generation for hazards/barrier.
// Ports:
//   clk, rst (sync, active-high)
//   issue_valid/opcode/unit_sel, vd/vs1/vs2 + enables: decode request
//   done/done_wr/done_vd: per-unit completions (done_vd sliced per unit)
//   stall/issue_fire: handshake back to decode
//   vreg_busy, idle, stall_cnt, err_underflow: status
module vpu_stall_ctrl #(
  parameter int OPCODE_W = 7,
  parameter logic [OPCODE_W-1:0] BARRIER_OP = 7'b1111111,
  parameter int NUM_VREGS = 32,
  parameter int VREG_AW = 5,
  parameter int NUM_UNITS = 2,
  parameter int UNIT_W = 1,
  parameter int MAX_OUT = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [OPCODE_W-1:0]          opcode,
  input  logic [UNIT_W-1:0]            unit_sel,
  input  logic [VREG_AW-1:0]           vd,
  input  logic [VREG_AW-1:0]           vs1,
  input  logic [VREG_AW-1:0]           vs2,
  input  logic                         vd_en,
  input  logic                         vs1_en,
  input  logic                         vs2_en,
  input  logic [NUM_UNITS-1:0]         done,
  input  logic [NUM_UNITS-1:0]         done_wr,
  input  logic [NUM_UNITS*VREG_AW-1:0] done_vd,
  output logic                         stall,
  output logic                         issue_fire,
  output logic [NUM_VREGS-1:0]         vreg_busy,
  output logic                         idle,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic                         err_underflow
);

  localparam int OCW = $clog2(MAX_OUT) + 1;
  localparam int XREGS = 2 ** VREG_AW;

  logic [NUM_VREGS-1:0] busy_q, busy_d;
  logic [OCW-1:0]       cnt_q [NUM_UNITS];
  logic [OCW-1:0]       cnt_d [NUM_UNITS];
  logic [CNT_W-1:0]     scnt_q, scnt_d;
  logic                 err_q, err_d;

  // Index space padded to the full address range so that
  // out-of-range indices read as not busy and are never set.
  logic [XREGS-1:0] busy_ext;
  logic [XREGS-1:0] set_ext;
  logic [XREGS-1:0] clr_ext;

  logic is_bar;
  logic raw;
  logic waw;
  logic full;
  logic cnt_zero;
  logic uf;
  logic inc;

  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_VREGS-1:0] = busy_q;
    is_bar = (opcode == BARRIER_OP);
    raw = (vs1_en & busy_ext[vs1]) |
          (vs2_en & busy_ext[vs2]);
    waw = vd_en & busy_ext[vd];
    full = 1'b0;
    cnt_zero = 1'b1;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (unit_sel == UNIT_W'(u) &&
          cnt_q[u] == OCW'(MAX_OUT))
        full = 1'b1;
      if (cnt_q[u] != '0)
        cnt_zero = 1'b0;
    end
    idle = (busy_q == '0) & cnt_zero;
    stall = issue_valid &
            (raw | waw |
             (~is_bar & full) |
             (is_bar & ~idle));
    issue_fire = issue_valid & ~stall;
  end

  always_comb begin
    set_ext = '0;
    if (issue_fire && !is_bar && vd_en)
      set_ext[vd] = 1'b1;
    clr_ext = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (done[u] && done_wr[u])
        clr_ext[done_vd[u*VREG_AW +: VREG_AW]] = 1'b1;
    end
    // Set after clear: a same-cycle set of a register wins.
    busy_d = (busy_q & ~clr_ext[NUM_VREGS-1:0]) |
             set_ext[NUM_VREGS-1:0];

    uf = 1'b0;
    inc = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      inc = issue_fire & ~is_bar &
            (unit_sel == UNIT_W'(u));
      cnt_d[u] = cnt_q[u];
      if (done[u] && cnt_q[u] == '0)
        uf = 1'b1;
      if (inc && !done[u])
        cnt_d[u] = cnt_q[u] + OCW'(1);
      else if (!inc && done[u] && cnt_q[u] != '0)
        cnt_d[u] = cnt_q[u] - OCW'(1);
    end
    err_d = err_q | uf;

    scnt_d = scnt_q;
    if (stall && scnt_q != '1)
      scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++)
        cnt_q[u] <= '0;
    end else begin
      busy_q <= busy_d;
      scnt_q <= scnt_d;
      err_q  <= err_d;
      for (int u = 0; u < NUM_UNITS; u++)
        cnt_q[u] <= cnt_d[u];
    end
  end

  assign vreg_busy     = busy_q;
  assign stall_cnt     = scnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_vpu_stall_ctrl.sv
// Directed table-driven bench for vpu_stall_ctrl (CNT_W=4 build so the
// stall counter saturation is reachable quickly).
module tb_vpu_stall_ctrl;

  localparam int CW = 4;
  localparam logic [6:0] OP  = 7'h01;
  localparam logic [6:0] BAR = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [6:0]  opcode;
  logic        unit_sel;
  logic [4:0]  vd, vs1, vs2;
  logic        vd_en, vs1_en, vs2_en;
  logic [1:0]  done, done_wr;
  logic [9:0]  done_vd;
  logic        stall, issue_fire, idle, err_underflow;
  logic [31:0] vreg_busy;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vpu_stall_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .opcode(opcode),
    .unit_sel(unit_sel),
    .vd(vd), .vs1(vs1), .vs2(vs2),
    .vd_en(vd_en), .vs1_en(vs1_en), .vs2_en(vs2_en),
    .done(done), .done_wr(done_wr), .done_vd(done_vd),
    .stall(stall), .issue_fire(issue_fire),
    .vreg_busy(vreg_busy), .idle(idle),
    .stall_cnt(stall_cnt),
    .err_underflow(err_underflow)
  );

  typedef struct {
    logic        rst, iv;
    logic [6:0]  op;
    logic        us;
    logic [4:0]  vd, vs1, vs2;
    logic [2:0]  en;
    logic [1:0]  dn, dwr;
    logic [4:0]  dvd0, dvd1;
    logic        e_stall, e_fire;
    logic [31:0] e_busy;
    logic        e_idle;
    logic [CW-1:0] e_scnt;
    logic        e_err;
  } vec_t;

  vec_t tq[$];

  function automatic vec_t v(
    input logic r, input logic iv, input logic [6:0] op,
    input logic us, input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [2:0] en,
    input logic [1:0] dn, input logic [1:0] dwr,
    input logic [4:0] dv0, input logic [4:0] dv1,
    input logic es, input logic ef, input logic [31:0] eb,
    input logic ei, input int esc, input logic ee);
    vec_t t;
    t.rst = r; t.iv = iv; t.op = op; t.us = us;
    t.vd = d; t.vs1 = s1; t.vs2 = s2; t.en = en;
    t.dn = dn; t.dwr = dwr; t.dvd0 = dv0; t.dvd1 = dv1;
    t.e_stall = es; t.e_fire = ef; t.e_busy = eb;
    t.e_idle = ei; t.e_scnt = CW'(esc); t.e_err = ee;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; issue_valid = t.iv; opcode = t.op;
    unit_sel = t.us; vd = t.vd; vs1 = t.vs1; vs2 = t.vs2;
    {vd_en, vs1_en, vs2_en} = t.en;
    done = t.dn; done_wr = t.dwr;
    done_vd = {t.dvd1, t.dvd0};
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    chk("stall", idx, 32'(stall), 32'(t.e_stall));
    chk("fire", idx, 32'(issue_fire), 32'(t.e_fire));
    chk("busy", idx, vreg_busy, t.e_busy);
    chk("idle", idx, 32'(idle), 32'(t.e_idle));
    chk("scnt", idx, 32'(stall_cnt), 32'(t.e_scnt));
    chk("err", idx, 32'(err_underflow), 32'(t.e_err));
    @(posedge clk);
  endtask

  initial begin
    vec_t t;
    int   exp_s;
    t = v(1,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,0,0);
    drive(t);
    repeat (2) @(posedge clk);

    // RAW on vs1 with done release
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,0,0));
    tq.push_back(v(0,1,OP,0,3,0,0,3'b100,0,0,0,0, 0,1,0,1,0,0));
    tq.push_back(v(0,1,OP,0,4,3,0,3'b110,0,0,0,0, 1,0,32'h8,0,0,0));
    tq.push_back(v(0,1,OP,0,4,3,0,3'b110,0,0,0,0, 1,0,32'h8,0,1,0));
    tq.push_back(v(0,1,OP,0,4,3,0,3'b110,1,1,3,0, 1,0,32'h8,0,2,0));
    tq.push_back(v(0,1,OP,0,4,3,0,3'b110,0,0,0,0, 0,1,0,1,3,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,1,1,4,0, 0,0,32'h10,0,3,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,3,0));
    // unit1 fills to MAX_OUT
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,0,0,0,0, 0,1,0,1,3,0));
    for (int i = 0; i < 3; i++)
      tq.push_back(v(0,1,OP,1,0,0,0,3'b000,0,0,0,0, 0,1,0,0,3,0));
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,0,0,0,0, 1,0,0,0,3,0));
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,2,0,0,0, 1,0,0,0,4,0));
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,0,0,0,0, 0,1,0,0,5,0));
    for (int i = 0; i < 4; i++)
      tq.push_back(v(0,0,OP,0,0,0,0,3'b000,2,0,0,0, 0,0,0,0,5,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,5,0));
    // issue and done on same unit leave counter unchanged
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,0,0,0,0, 0,1,0,1,5,0));
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,2,0,0,0, 0,1,0,0,5,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,2,0,0,0, 0,0,0,0,5,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,5,0));
    // barrier waits for unit0 count of 2
    tq.push_back(v(0,1,OP,0,0,0,0,3'b000,0,0,0,0, 0,1,0,1,5,0));
    tq.push_back(v(0,1,OP,0,0,0,0,3'b000,0,0,0,0, 0,1,0,0,5,0));
    tq.push_back(v(0,1,BAR,1,0,0,0,3'b000,0,0,0,0, 1,0,0,0,5,0));
    tq.push_back(v(0,1,BAR,1,0,0,0,3'b000,1,0,0,0, 1,0,0,0,6,0));
    tq.push_back(v(0,1,BAR,1,0,0,0,3'b000,1,0,0,0, 1,0,0,0,7,0));
    tq.push_back(v(0,1,BAR,1,0,0,0,3'b000,0,0,0,0, 0,1,0,1,8,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,8,0));
    // WAW on v7, done in same cycle gives no bypass
    tq.push_back(v(0,1,OP,0,7,0,0,3'b100,0,0,0,0, 0,1,0,1,8,0));
    tq.push_back(v(0,1,OP,1,7,0,0,3'b100,0,0,0,0, 1,0,32'h80,0,8,0));
    tq.push_back(v(0,1,OP,1,7,0,0,3'b100,1,1,7,0, 1,0,32'h80,0,9,0));
    tq.push_back(v(0,1,OP,1,7,0,0,3'b100,0,0,0,0, 0,1,0,1,10,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,32'h80,0,10,0));
    // set of v9 wins over same-cycle clear of v9
    tq.push_back(v(0,1,OP,0,9,0,0,3'b100,2,2,0,9, 0,1,32'h80,0,10,0));
    tq.push_back(v(0,1,OP,1,0,0,0,3'b000,0,0,0,0, 0,1,32'h280,0,10,0));
    // two units clear distinct registers together
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,3,3,9,7, 0,0,32'h280,0,10,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,10,0));
    // underflow is sticky, counter stays at zero
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,1,0,0,0, 0,0,0,1,10,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,10,1));
    tq.push_back(v(0,1,OP,0,0,0,0,3'b000,0,0,0,0, 0,1,0,1,10,1));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,1,0,0,0, 0,0,0,0,10,1));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,10,1));
    // reset clears everything; mid-op reset drops tracking
    tq.push_back(v(1,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,10,1));
    tq.push_back(v(0,1,OP,0,0,0,0,3'b000,0,0,0,0, 0,1,0,1,0,0));
    tq.push_back(v(1,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,0,0,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,1,0,0,0, 0,0,0,1,0,0));
    tq.push_back(v(0,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,0,1));

    foreach (tq[i]) run(tq[i], i);

    // stall counter saturation
    @(negedge clk);
    t = v(1,0,OP,0,0,0,0,3'b000,0,0,0,0, 0,0,0,1,0,0);
    drive(t);
    @(posedge clk);
    @(negedge clk);
    t = v(0,1,OP,0,1,0,0,3'b100,0,0,0,0, 0,1,0,1,0,0);
    drive(t);
    @(posedge clk);
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      @(negedge clk);
      t = v(0,1,OP,1,2,1,0,3'b110,0,0,0,0, 1,0,32'h2,0,0,0);
      drive(t);
      #1;
      exp_s = (i > 15) ? 15 : i;
      chk("sat_stall", i, 32'(stall), 32'd1);
      chk("sat_cnt", i, 32'(stall_cnt), 32'(exp_s));
      @(posedge clk);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("sat_final", 99, 32'(stall_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
